// File: rtl/core_mem_responder.sv
// core_mem_responder: word memory with byte-strobe writes and a fixed-latency
// read pipeline. Optional mem_err output when CORE_MEM_RESP_ERR_EN is defined.
//
// Ports:
//   CLK, RSTN            clock, async active-low reset
//   mem_en               request strobe (never stalled)
//   mem_addr             byte address
//   mem_wdata, mem_wen   write data and byte enables (wen==0 means read)
//   mem_rdata, mem_rvld  read data, held between valid pulses
//   mem_err              (macro only) out-of-range or misaligned access
module core_mem_responder #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / BYTE_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'hFFFF_1000,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  mem_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_wen,
`ifdef CORE_MEM_RESP_ERR_EN
  output logic                  mem_err,
`endif
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvld
);

  localparam int unsigned SW = $clog2(STRB_WIDTH);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH_WORDS * STRB_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_inr;
  logic [IW-1:0]         w_idx;
  logic                  w_rd;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_rword;

  logic [READ_LATENCY-1:0]                 r_vld;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] r_dat;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign w_off   = mem_addr - BASE_ADDR;
  assign w_inr   = ({1'b0, w_off} < LIMIT);
  assign w_idx   = w_off[SW +: IW];
  assign w_rd    = mem_en && (mem_wen == '0);
  assign w_wr    = mem_en && (mem_wen != '0) && w_inr;
  assign w_rword = w_inr ? r_mem[w_idx] : '0;

  // Array contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (mem_wen[i]) begin
          r_mem[w_idx][i*BYTE_WIDTH +: BYTE_WIDTH]
            <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Data of a stage only moves when a valid entry enters it, so the
  // last stage (mem_rdata) holds between read pulses.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) r_dat[0] <= w_rword;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign mem_rvld  = r_vld[READ_LATENCY-1];
  assign mem_rdata = r_dat[READ_LATENCY-1];

`ifdef CORE_MEM_RESP_ERR_EN
  logic                    w_bad;
  logic [READ_LATENCY-1:0] r_err;
  logic                    r_werr;

  assign w_bad = !w_inr || (mem_addr[1:0] != 2'b00);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_err  <= '0;
      r_werr <= 1'b0;
    end else begin
      r_err[0] <= w_rd && w_bad;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_err[i] <= r_err[i-1];
      end
      r_werr <= mem_en && (mem_wen != '0) && w_bad;
    end
  end

  assign mem_err = (r_vld[READ_LATENCY-1] && r_err[READ_LATENCY-1])
                 || r_werr;
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder: randomized scoreboard bench for core_mem_responder.
// Driver updates a byte-level memory model; monitor checks at negedge.
module tb_core_mem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'hFFFF_1000;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        mem_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wen = '0;
  logic [31:0] mem_rdata;
  logic        mem_rvld;
`ifdef CORE_MEM_RESP_ERR_EN
  logic        mem_err;
`endif

  core_mem_responder #(
    .BASE_ADDR(BASE),
    .DEPTH_WORDS(DEPTH),
    .READ_LATENCY(LAT)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wen(mem_wen),
`ifdef CORE_MEM_RESP_ERR_EN
    .mem_err(mem_err),
`endif
    .mem_rdata(mem_rdata),
    .mem_rvld(mem_rvld)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          dc;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   werr_q[$];

  logic [31:0] mdl [DEPTH];
  bit          known [DEPTH];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h cycle %0d",
                  nm, act, exp, cyc);
  endtask

  task automatic fail(input string nm);
    n_tot++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Monitor: compares DUT outputs against scoreboard entries.
  initial begin
    logic [31:0] hold;
    bit          ee;
    exp_t        e;
    hold = '0;
    forever begin
      @(negedge CLK);
      ee = 1'b0;
      if (!RSTN) begin
        chk("rst_rvld", {31'd0, mem_rvld}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        hold = '0;
      end else begin
        if (mem_rvld) begin
          if (q.size() == 0) begin
            fail("unexpected_rvld");
          end else begin
            e = q.pop_front();
            chk("rvld_cycle", cyc, e.due);
            if (!e.dc) chk("rdata", mem_rdata, e.data);
            ee = e.err;
          end
          hold = mem_rdata;
        end else begin
          chk("rdata_hold", mem_rdata, hold);
        end
        while (q.size() != 0 && q[0].due < cyc) begin
          fail("missing_rvld");
          void'(q.pop_front());
        end
`ifdef CORE_MEM_RESP_ERR_EN
        while (werr_q.size() != 0 && werr_q[0] < cyc)
          void'(werr_q.pop_front());
        if (werr_q.size() != 0 && werr_q[0] == cyc) begin
          ee = 1'b1;
          void'(werr_q.pop_front());
        end
        chk("mem_err", {31'd0, mem_err}, {31'd0, ee});
`endif
      end
    end
  end

  task automatic idle();
    @(negedge CLK); #1;
    mem_en = 1'b0;
    mem_wen = '0;
  endtask

  // Issue one request; expected effects derived from byte-address rules.
  task automatic op(input logic [31:0] a, input logic [3:0] wen,
                    input logic [31:0] wd);
    logic [31:0] off;
    bit          inr;
    bit          err;
    int          idx;
    exp_t        e;
    @(negedge CLK); #1;
    mem_en = 1'b1;
    mem_addr = a;
    mem_wen = wen;
    mem_wdata = wd;
    off = a - BASE;
    inr = (off < DEPTH * 4);
    idx = int'(off / 4);
    err = !inr || (a % 4 != 0);
    if (wen == 4'h0) begin
      e.due  = cyc + LAT;
      e.data = inr ? mdl[idx] : 32'd0;
      e.dc   = inr && !known[idx];
      e.err  = err;
      q.push_back(e);
    end else begin
      if (inr) begin
        for (int b = 0; b < 4; b++)
          if (wen[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
        if (wen == 4'hF) known[idx] = 1'b1;
      end
      if (err) werr_q.push_back(cyc + 1);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK); #1;
    RSTN = 1'b0;
    mem_en = 1'b0;
    mem_wen = '0;
    q.delete();
    werr_q.delete();
    repeat (n) @(negedge CLK);
    #1 RSTN = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = '0;
      known[i] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    #1 RSTN = 1'b1;

    // Read with no prior write, then a read killed by reset.
    op(BASE, 4'h0, '0);
    idle();
    repeat (LAT + 1) idle();
    op(BASE, 4'h0, '0);
    do_reset(2);
    repeat (LAT + 2) idle();

    for (int i = 0; i < DEPTH; i++)
      op(BASE + 32'(i * 4), 4'hF, $urandom);

    op(32'hFFFF_1004, 4'hF, 32'hDEAD_BEEF);
    op(32'hFFFF_1004, 4'h0, '0);
    op(32'hFFFF_1004, 4'b0101, 32'h1122_3344);
    op(32'hFFFF_1004, 4'h0, '0);
    idle();

    op(32'hFFFF_1000, 4'hF, 32'd1);
    op(32'hFFFF_1004, 4'hF, 32'd2);
    op(32'hFFFF_1008, 4'hF, 32'd3);
    op(32'hFFFF_1000, 4'h0, '0);
    op(32'hFFFF_1004, 4'h0, '0);
    op(32'hFFFF_1008, 4'h0, '0);
    idle();

    op(32'hFFFF_2000, 4'h0, '0);
    op(32'hFFFF_0FFC, 4'hF, 32'hAAAA_AAAA);
    idle();

    op(32'hFFFF_1000, 4'h0, '0);
    op(32'hFFFF_1000, 4'hF, 32'h5);
    op(32'hFFFF_1000, 4'h0, '0);
    op(32'hFFFF_1002, 4'h0, '0);
    idle();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle();
      end else begin
        if ($urandom_range(0, 99) < 85)
          a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4)
            + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 0);
        else if ($urandom_range(0, 1) == 0)
          a = BASE - 32'($urandom_range(1, 64));
        else
          a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
        w = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
        op(a, w, $urandom);
      end
    end

    for (int i = 0; i < DEPTH; i++)
      op(BASE + 32'(i * 4), 4'h0, '0);
    repeat (LAT + 3) idle();
    chk("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Memory-side responder for the core bus request/response interface. Terminates the `core_bus_*_mem_*` signals driven by the bus, either the instruction side or the LSU/data side.
- Owns a word-organised memory with byte-strobe writes. Accepts one request per cycle and never stalls.
- Returns read data with a fixed, parameterised latency, qualified by `mem_rvld`.
- The bus registers `rdata` on `rvld`, so `rdata` must be stable whenever `rvld` is high.

Parameters:
- BASE_ADDR, 32'hFFFF_1000, first byte address decoded by this memory.
- DEPTH_WORDS, 1024, number of DATA_WIDTH words; power of two, at least 2.
- READ_LATENCY, 1, cycles from read acceptance to `mem_rvld`; legal range 1..4.
- BYTE_WIDTH, 8, bits per strobe lane.
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, byte address width.
- STRB_WIDTH, DATA_WIDTH/BYTE_WIDTH, number of write strobes.

Ports:
- CLK  in  1  single clock; all logic is on the rising edge.
- RSTN  in  1  asynchronous active-low reset.
- mem_en  in  1  request strobe; one request per cycle while high.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_wen  in  STRB_WIDTH  byte write enables; zero means read, non-zero means write.
- mem_rdata  out  DATA_WIDTH  read data, valid while mem_rvld is high.
- mem_rvld  out  1  one-cycle pulse per accepted read.

Behaviour:
- Reset:
  - mem_rdata=0, mem_rvld=0, and the latency pipeline is flushed.
  - Memory array contents are not reset.
  - Asserting RSTN low mid-operation discards all in-flight reads; no mem_rvld follows release.
- Address decode:
  - offset = mem_addr - BASE_ADDR, computed in ADDR_WIDTH bits with unsigned wrap.
  - In range: offset < DEPTH_WORDS*STRB_WIDTH. Word index = offset >> log2(STRB_WIDTH). Low address bits are ignored, so misaligned addresses access the containing word.
- Write (mem_en=1, mem_wen!=0):
  - At the accepting edge, each lane i with mem_wen[i]=1 is updated with its byte of mem_wdata. Other lanes are unchanged.
  - Out-of-range writes are silently dropped.
  - Writes never produce mem_rvld.
- Read (mem_en=1, mem_wen==0):
  - The word is sampled at the accepting edge, cycle k, and enters the pipeline.
  - mem_rvld=1 and mem_rdata=word in cycle k+READ_LATENCY.
  - Out-of-range reads still return mem_rvld, with mem_rdata=0.
- Pipeline:
  - Shift register of READ_LATENCY stages, each holding {valid, data}. Back-to-back reads every cycle are fully supported.
  - mem_rvld is high for consecutive cycles when reads are consecutive.
- mem_rdata holds its last value while mem_rvld=0. It is updated only when the output stage is valid.
- Ordering:
  - A write in cycle k followed by a read of the same word in cycle k+1 returns the new data.
  - Data already in the pipeline is not modified by later writes. Snapshot semantics: no forwarding into in-flight reads.
- mem_en=0: inputs are ignored and no state changes except pipeline advance.
- No backpressure exists. The responder is always ready, matching the bus, which has no ready signal.

Optional Feature:
- Macro: CORE_MEM_RESP_ERR_EN.
- Defined:
  - Adds output `mem_err` (1 bit, reset 0).
  - For reads, mem_err pulses aligned with mem_rvld when the read was out of range or mem_addr[1:0]!=0.
  - For writes, mem_err pulses one cycle after acceptance under the same conditions. The out-of-range write is still dropped; a misaligned write still performs the aligned-word update.
- Undefined: no mem_err port exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then read at 0xFFFF_1000 without any prior write, READ_LATENCY=1 → mem_rvld high exactly 1 cycle later. Assert RSTN low during the next read's latency → mem_rvld stays 0 and mem_rdata=0.
- Write 0xDEADBEEF with wen=4'hF to 0xFFFF_1004, then read 0xFFFF_1004 the next cycle → mem_rdata=0xDEADBEEF, mem_rvld for exactly one cycle.
- Write wen=4'b0101, wdata=0x11223344 over 0xDEADBEEF at 0xFFFF_1004, then read → 0xDE22BE44.
- READ_LATENCY=3, reads to 0xFFFF_1000, 1004, 1008 on three consecutive cycles, preloaded with 1, 2, 3 → mem_rvld high for 3 consecutive cycles starting 3 cycles after the first read, with data 1, 2, 3 in order.
- Read 0xFFFF_2000 (out of range), then write 0xAAAA_AAAA to 0xFFFF_0FFC → rvld with rdata=0, and the write leaves all memory unchanged. With CORE_MEM_RESP_ERR_EN defined: mem_err pulses aligned with that rvld, and one cycle after the write.
- Read 0xFFFF_1000, then write 0x5 to the same word one cycle later, READ_LATENCY=2 → the read returns the old value; a subsequent read returns 0x5.
